mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 6, word-address width of internal data memory (2^ADDR_BITS x 16-bit words).
REQ-002 SHALL have port clkwire  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstwire_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  EX/MEM instruction present.
REQ-005 SHALL have port in_ready  output  1  stage can accept; transfer when in_valid && in_ready at rising edge.
REQ-006 SHALL have port opcode  input  4  ADD=0000 SUB=0001 MUL=0010 LW=0011 SW=0100 BEQ=0101 BNE=0110.
REQ-007 SHALL have port alu_result  input  16  ALU result; memory word address for LW/SW.
REQ-008 SHALL have port store_data  input  16  data written by SW.
REQ-009 SHALL have port dest_reg  input  4  destination register number.
REQ-010 SHALL have port writeToReg  output  1  register-write strobe to write-back stage.
REQ-011 SHALL have port writeData  output  16  data for write-back.
REQ-012 SHALL have port regNos  output  4  destination register for write-back.
REQ-013 SHALL have port addr_err  output  1  one-cycle pulse on out-of-range LW/SW address.

Function
REQ-014 SHALL implement FSM states IDLE and LOAD; in_ready = 1 only in IDLE.
REQ-015 ADD/SUB/MUL accepted at edge N SHALL give at edge N+1: writeToReg=1, writeData=alu_result, regNos=dest_reg (latency 1).
REQ-016 SW accepted at edge N SHALL write store_data to mem[alu_result[ADDR_BITS-1:0]] at edge N and give writeToReg=0 at N+1.
REQ-017 LW accepted at edge N SHALL move IDLE->LOAD, capture address/dest_reg, and at edge N+1 read memory and return to IDLE with writeToReg=1, writeData=mem word, regNos=dest_reg (latency 2, in_ready low one cycle).
REQ-018 BEQ, BNE and opcodes 0111-1111 SHALL produce writeToReg=0 and no memory access.
REQ-019 writeToReg SHALL be a single-cycle pulse per writing instruction; 0 on cycles with no completing instruction.
REQ-020 writeData/regNos SHALL hold last values while writeToReg=0.
REQ-021 dest_reg >= 8 SHALL force writeToReg=0 for that instruction (write-back decodes 0-7 only); SW still performed.
REQ-022 alu_result[15:ADDR_BITS] != 0 SHALL: drop SW write; LW returns writeData=16'h0000 with writeToReg=1; addr_err=1 in the cycle writeToReg/result would appear.
REQ-023 SW at edge N followed by LW at N+1 to same address SHALL return the new data.
REQ-024 Input in_valid while in LOAD SHALL be ignored (not accepted); upstream holds it.

Reset
REQ-025 rstwire_n=0 SHALL immediately force state=IDLE, in_ready=1, writeToReg=0, writeData=16'h0000, regNos=4'h0, addr_err=0.
REQ-026 Reset during LOAD SHALL discard the pending load; no writeToReg after release.
REQ-027 Memory contents SHALL be unaffected by reset (undefined until written).

Verification
REQ-028 ADD, alu_result=16'h0025, dest_reg=3 -> next edge writeToReg=1, writeData=0025, regNos=3, then writeToReg=0.
REQ-029 SW store_data=16'hBEEF addr 5, then LW addr 5 dest 7 -> in_ready low one cycle; writeToReg=1, writeData=BEEF, regNos=7 two edges after LW accept.
REQ-030 LW alu_result=16'h0040 (ADDR_BITS=6) -> writeData=0000, writeToReg=1, addr_err pulse; SW to 16'h0040 -> memory unchanged, addr_err pulse.
REQ-031 BEQ/BNE/opcode 1111 and ADD with dest_reg=9 -> writeToReg stays 0, writeData/regNos unchanged.
REQ-032 rstwire_n low mid-LOAD -> outputs at reset values immediately, in_ready=1, no writeToReg after release.

Source files
------------

// File: rtl/mem_access.sv
// mem_access -- MEM stage of a small in-order pipeline.
//
// Takes one instruction per transfer from EX/MEM and produces a registered
// write-back strobe/data/register triple. ALU ops retire one edge after
// acceptance. SW writes the internal data memory on the accept edge. LW
// parks in LOAD for one cycle (in_ready low), then reads the captured
// address and retires on the following edge. Out-of-range addresses (any
// alu_result bit at or above ADDR_BITS set) drop the store or return zero,
// and raise a one-cycle addr_err pulse alongside the result.
//
// Ports
//   clkwire     in   clock, rising edge
//   rstwire_n   in   async active-low reset (memory contents not reset)
//   in_valid    in   instruction present
//   in_ready    out  stage can accept (IDLE only)
//   opcode      in   [3:0]  ADD/SUB/MUL/LW/SW/BEQ/BNE
//   alu_result  in   [15:0] ALU result / word address for LW, SW
//   store_data  in   [15:0] SW data
//   dest_reg    in   [3:0]  destination register
//   writeToReg  out  write-back strobe, one cycle per writing instruction
//   writeData   out  [15:0] write-back data (held while strobe low)
//   regNos      out  [3:0]  write-back register (held while strobe low)
//   addr_err    out  one-cycle pulse for out-of-range LW/SW
module mem_access #(
   parameter int ADDR_BITS = 6
) (
   input  logic        clkwire,
   input  logic        rstwire_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  opcode,
   input  logic [15:0] alu_result,
   input  logic [15:0] store_data,
   input  logic [3:0]  dest_reg,
   output logic        writeToReg,
   output logic [15:0] writeData,
   output logic [3:0]  regNos,
   output logic        addr_err
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_LW  = 4'b0011;
   localparam logic [3:0] OP_SW  = 4'b0100;

   typedef enum logic {S_IDLE, S_LOAD} state_t;

   state_t                 r_state, w_next_state;
   logic [15:0]            r_mem [2**ADDR_BITS];

   // Load captured on accept, consumed in LOAD
   logic [ADDR_BITS-1:0]   r_ld_addr;
   logic [3:0]             r_ld_dest;
   logic                   r_ld_ok;

   logic                   r_wr, r_err;
   logic [15:0]            r_wdata;
   logic [3:0]             r_regno;

   logic                   w_accept, w_addr_ok, w_mem_we, w_cap_ld;
   logic                   w_wr, w_err;
   logic [15:0]            w_wdata, w_rdata;
   logic [3:0]             w_regno;

   assign in_ready   = (r_state == S_IDLE);
   assign w_accept   = in_valid && in_ready;
   assign w_addr_ok  = ((alu_result >> ADDR_BITS) == 16'h0000);
   assign w_rdata    = r_mem[r_ld_addr];

   assign writeToReg = r_wr;
   assign writeData  = r_wdata;
   assign regNos     = r_regno;
   assign addr_err   = r_err;

   always_ff @(posedge clkwire or negedge rstwire_n) begin
      if (!rstwire_n) r_state <= S_IDLE;
      else            r_state <= w_next_state;
   end

   // Next state plus next write-back values. Data/register only change on a
   // real write so they hold across non-writing instructions.
   always_comb begin
      w_next_state = r_state;
      w_wr         = 1'b0;
      w_err        = 1'b0;
      w_wdata      = r_wdata;
      w_regno      = r_regno;
      w_mem_we     = 1'b0;
      w_cap_ld     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (opcode)
                  OP_ADD, OP_SUB, OP_MUL: begin
                     // Write-back only decodes registers 0-7
                     if (!dest_reg[3]) begin
                        w_wr    = 1'b1;
                        w_wdata = alu_result;
                        w_regno = dest_reg;
                     end
                  end
                  OP_LW: begin
                     w_next_state = S_LOAD;
                     w_cap_ld     = 1'b1;
                  end
                  OP_SW: begin
                     w_mem_we = w_addr_ok;
                     w_err    = !w_addr_ok;
                  end
                  default: ;
               endcase
            end
         end
         S_LOAD: begin
            w_next_state = S_IDLE;
            w_err        = !r_ld_ok;
            if (!r_ld_dest[3]) begin
               w_wr    = 1'b1;
               w_wdata = r_ld_ok ? w_rdata : 16'h0000;
               w_regno = r_ld_dest;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clkwire or negedge rstwire_n) begin
      if (!rstwire_n) begin
         r_wr      <= 1'b0;
         r_err     <= 1'b0;
         r_wdata   <= 16'h0000;
         r_regno   <= 4'h0;
         r_ld_addr <= '0;
         r_ld_dest <= 4'h0;
         r_ld_ok   <= 1'b0;
      end else begin
         r_wr    <= w_wr;
         r_err   <= w_err;
         r_wdata <= w_wdata;
         r_regno <= w_regno;
         if (w_cap_ld) begin
            r_ld_addr <= alu_result[ADDR_BITS-1:0];
            r_ld_dest <= dest_reg;
            r_ld_ok   <= w_addr_ok;
         end
      end
   end

   // Memory is deliberately outside reset
   always_ff @(posedge clkwire) begin
      if (w_mem_we) r_mem[alu_result[ADDR_BITS-1:0]] <= store_data;
   end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access -- table of instruction vectors with a scoreboard queue,
// plus hand sequences for back-to-back SW/LW, hold during LOAD and reset
// in the middle of a load.
module tb_mem_access;

   logic        clkwire = 1'b0;
   logic        rstwire_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  opcode = 4'h0;
   logic [15:0] alu_result = 16'h0;
   logic [15:0] store_data = 16'h0;
   logic [3:0]  dest_reg = 4'h0;
   logic        writeToReg;
   logic [15:0] writeData;
   logic [3:0]  regNos;
   logic        addr_err;

   mem_access #(.ADDR_BITS(6)) dut (
      .clkwire(clkwire), .rstwire_n(rstwire_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .alu_result(alu_result), .store_data(store_data),
      .dest_reg(dest_reg), .writeToReg(writeToReg), .writeData(writeData),
      .regNos(regNos), .addr_err(addr_err)
   );

   always #5 clkwire = ~clkwire;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] alu;
      logic [15:0] sd;
      logic [3:0]  dest;
      logic        wr;
      logic [15:0] wd;
      logic [3:0]  rn;
      logic        err;
   } vec_t;

   localparam int NV = 22;
   vec_t tbl [NV];
   vec_t sb [$];

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Issue one vector; caller is at posedge+1
   task automatic send(input vec_t v, input int idx);
      int   g;
      vec_t e;
      string p;
      p = $sformatf("v%0d", idx);
      g = 0;
      opcode = v.op; alu_result = v.alu; store_data = v.sd; dest_reg = v.dest;
      in_valid = 1'b1;
      while (!in_ready && g < 8) begin @(posedge clkwire); #1; g++; end
      chk({p, ".ready_at_issue"}, {15'h0, in_ready}, 16'h1);
      sb.push_back(v);
      @(posedge clkwire); #1;
      in_valid = 1'b0;
      if (v.op == 4'h3) begin
         chk({p, ".ready_low_load"}, {15'h0, in_ready}, 16'h0);
         chk({p, ".wr_low_load"}, {15'h0, writeToReg}, 16'h0);
         @(posedge clkwire); #1;
      end
      e = sb.pop_front();
      chk({p, ".wr"}, {15'h0, writeToReg}, {15'h0, e.wr});
      chk({p, ".wdata"}, writeData, e.wd);
      chk({p, ".regno"}, {12'h0, regNos}, {12'h0, e.rn});
      chk({p, ".err"}, {15'h0, addr_err}, {15'h0, e.err});
      @(posedge clkwire); #1;
      chk({p, ".idle_wr"}, {15'h0, writeToReg}, 16'h0);
      chk({p, ".idle_err"}, {15'h0, addr_err}, 16'h0);
      chk({p, ".idle_wdata"}, writeData, e.wd);
      chk({p, ".idle_regno"}, {12'h0, regNos}, {12'h0, e.rn});
   endtask

   task automatic chk_reset_vals(input string p);
      chk({p, ".ready"}, {15'h0, in_ready}, 16'h1);
      chk({p, ".wr"}, {15'h0, writeToReg}, 16'h0);
      chk({p, ".wdata"}, writeData, 16'h0000);
      chk({p, ".regno"}, {12'h0, regNos}, 16'h0);
      chk({p, ".err"}, {15'h0, addr_err}, 16'h0);
   endtask

   initial begin
      //          op     alu       sd       dest   wr    wd        rn     err
      tbl[0]  = '{4'h0, 16'h0025, 16'h0000, 4'd3,  1'b1, 16'h0025, 4'd3, 1'b0};
      tbl[1]  = '{4'h1, 16'h1234, 16'h0000, 4'd0,  1'b1, 16'h1234, 4'd0, 1'b0};
      tbl[2]  = '{4'h2, 16'hFFFF, 16'h0000, 4'd7,  1'b1, 16'hFFFF, 4'd7, 1'b0};
      tbl[3]  = '{4'h4, 16'h0005, 16'hBEEF, 4'd2,  1'b0, 16'hFFFF, 4'd7, 1'b0};
      tbl[4]  = '{4'h3, 16'h0005, 16'h0000, 4'd7,  1'b1, 16'hBEEF, 4'd7, 1'b0};
      tbl[5]  = '{4'h4, 16'h003F, 16'h1111, 4'd1,  1'b0, 16'hBEEF, 4'd7, 1'b0};
      tbl[6]  = '{4'h3, 16'h003F, 16'h0000, 4'd1,  1'b1, 16'h1111, 4'd1, 1'b0};
      tbl[7]  = '{4'h4, 16'h0000, 16'h1357, 4'd0,  1'b0, 16'h1111, 4'd1, 1'b0};
      tbl[8]  = '{4'h3, 16'h0040, 16'h0000, 4'd4,  1'b1, 16'h0000, 4'd4, 1'b1};
      tbl[9]  = '{4'h4, 16'h0040, 16'hCAFE, 4'd0,  1'b0, 16'h0000, 4'd4, 1'b1};
      tbl[10] = '{4'h3, 16'h0000, 16'h0000, 4'd6,  1'b1, 16'h1357, 4'd6, 1'b0};
      tbl[11] = '{4'h5, 16'h0055, 16'h0000, 4'd2,  1'b0, 16'h1357, 4'd6, 1'b0};
      tbl[12] = '{4'h6, 16'h0066, 16'h0000, 4'd3,  1'b0, 16'h1357, 4'd6, 1'b0};
      tbl[13] = '{4'hF, 16'h0077, 16'h0000, 4'd4,  1'b0, 16'h1357, 4'd6, 1'b0};
      tbl[14] = '{4'h7, 16'h0088, 16'h0000, 4'd5,  1'b0, 16'h1357, 4'd6, 1'b0};
      tbl[15] = '{4'h0, 16'h00AA, 16'h0000, 4'd9,  1'b0, 16'h1357, 4'd6, 1'b0};
      tbl[16] = '{4'h4, 16'h0006, 16'h7777, 4'd12, 1'b0, 16'h1357, 4'd6, 1'b0};
      tbl[17] = '{4'h3, 16'h0006, 16'h0000, 4'd5,  1'b1, 16'h7777, 4'd5, 1'b0};
      tbl[18] = '{4'h3, 16'h0005, 16'h0000, 4'd8,  1'b0, 16'h7777, 4'd5, 1'b0};
      tbl[19] = '{4'h4, 16'h8005, 16'h4242, 4'd0,  1'b0, 16'h7777, 4'd5, 1'b1};
      tbl[20] = '{4'h3, 16'h0005, 16'h0000, 4'd2,  1'b1, 16'hBEEF, 4'd2, 1'b0};
      tbl[21] = '{4'h3, 16'h8005, 16'h0000, 4'd15, 1'b0, 16'hBEEF, 4'd2, 1'b1};

      // Reset: outputs must be at reset values before any clock edge
      #1 rstwire_n = 1'b0;
      #2 chk_reset_vals("rst0");
      @(posedge clkwire); @(posedge clkwire);
      @(negedge clkwire) rstwire_n = 1'b1;
      @(posedge clkwire); #1;

      for (int i = 0; i < NV; i++) send(tbl[i], i);

      // SW then LW on the very next edge, with an ADD held during LOAD
      opcode = 4'h4; alu_result = 16'h0009; store_data = 16'h5A5A; dest_reg = 4'd0;
      in_valid = 1'b1;
      @(posedge clkwire); #1;                       // SW accepted
      opcode = 4'h3; dest_reg = 4'd3;
      @(posedge clkwire); #1;                       // LW accepted
      chk("b2b.ready_low", {15'h0, in_ready}, 16'h0);
      chk("b2b.sw_wr", {15'h0, writeToReg}, 16'h0);
      opcode = 4'h0; alu_result = 16'h0BAD; dest_reg = 4'd1;   // held in LOAD
      @(posedge clkwire); #1;                       // LW retires, ADD ignored
      chk("b2b.ld_wr", {15'h0, writeToReg}, 16'h1);
      chk("b2b.ld_wdata", writeData, 16'h5A5A);
      chk("b2b.ld_regno", {12'h0, regNos}, 16'h3);
      chk("b2b.ready_back", {15'h0, in_ready}, 16'h1);
      @(posedge clkwire); #1;                       // ADD accepted now
      in_valid = 1'b0;
      chk("hold.add_wr", {15'h0, writeToReg}, 16'h1);
      chk("hold.add_wdata", writeData, 16'h0BAD);
      chk("hold.add_regno", {12'h0, regNos}, 16'h1);
      @(posedge clkwire); #1;
      chk("hold.idle_wr", {15'h0, writeToReg}, 16'h0);

      // Reset in the middle of a load
      opcode = 4'h3; alu_result = 16'h0005; dest_reg = 4'd4; in_valid = 1'b1;
      @(posedge clkwire); #1;
      in_valid = 1'b0;
      chk("rstld.in_load", {15'h0, in_ready}, 16'h0);
      #2 rstwire_n = 1'b0;
      #1 chk_reset_vals("rstld");
      @(negedge clkwire) rstwire_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clkwire); #1;
         chk($sformatf("rstld.post_wr%0d", k), {15'h0, writeToReg}, 16'h0);
      end
      chk("rstld.post_ready", {15'h0, in_ready}, 16'h1);
      chk("rstld.post_wdata", writeData, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
